half_dot_m_v: RTL

Backward-direction companion to the forward vector-times-matrix block. It computes vector_out[w] = sum over h of matrix[w][h]*vector[h] in IEEE-754 binary16, for example to propagate a delta vector back through a layer's weights. It uses one time-multiplexed half_dot_v_v instance of width HEIGHT, stepped row by row over WIDTH rows by an FSM. Area is traded for latency against the fully parallel forward block.

---
 rtl/half_dot_m_v.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/half_dot_m_v.sv
// half_dot_m_v: binary16 matrix-vector product, vector_out[w] = sum_h matrix[w][h]*vector[h].
// One time-multiplexed half_dot_v_v is stepped over the rows by a small FSM.

module half_dot_v_v #(
  parameter int HEIGHT = 10
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_start,
  input  logic [HEIGHT-1:0][15:0] i_vector_a,
  input  logic [HEIGHT-1:0][15:0] i_vector_b,
  output logic                    o_done,
  output logic [15:0]             o_c
);
  localparam int IW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  function automatic logic f_nan(input logic [15:0] a);
    return (&a[14:10]) && (|a[9:0]);
  endfunction
  function automatic logic f_inf(input logic [15:0] a);
    return (&a[14:10]) && !(|a[9:0]);
  endfunction
  function automatic logic f_zero(input logic [15:0] a);
    return !(|a[14:0]);
  endfunction
  function automatic int f_exp(input logic [15:0] a);
    return (a[14:10] == 5'd0) ? 1 : int'(a[14:10]);
  endfunction

  // Round s * sig * 2^ex to nearest-even binary16; subnormals kept, overflow saturates to inf.
  function automatic logic [15:0] f_pack(input logic s, input logic [41:0] sig, input int ex);
    int p, e, ec, sh, bits;
    logic [41:0] m, mask;
    logic rb, st;
    p = 0;
    for (int i = 0; i < 42; i++) if (sig[i]) p = i;
    if (sig == '0) return {s, 15'h0000};
    e = p + ex + 15;
    if (e > 30) return {s, 15'h7C00};
    ec = (e < 1) ? 1 : e;
    sh = ec - 25 - ex;
    rb = 1'b0;
    st = 1'b0;
    if (sh <= 0) begin
      m = sig << (-sh);
    end else begin
      m = sig >> sh;
      rb = sig[sh-1];
      mask = (42'd1 << (sh - 1)) - 42'd1;
      st = |(sig & mask);
    end
    m = m + {41'd0, rb & (st | m[0])};
    bits = (ec - 1) * 1024 + int'(m[12:0]);
    if (bits >= 31744) return {s, 15'h7C00};
    return {s, bits[14:0]};
  endfunction

  function automatic logic [15:0] f_mul(input logic [15:0] a, input logic [15:0] b);
    logic [10:0] ma, mb;
    logic [21:0] pr;
    if (f_nan(a) || f_nan(b) || (f_inf(a) && f_zero(b)) || (f_zero(a) && f_inf(b)))
      return 16'h7E00;
    if (f_inf(a) || f_inf(b)) return {a[15] ^ b[15], 15'h7C00};
    ma = {|a[14:10], a[9:0]};
    mb = {|b[14:10], b[9:0]};
    pr = ma * mb;
    return f_pack(a[15] ^ b[15], {20'd0, pr}, f_exp(a) + f_exp(b) - 50);
  endfunction

  function automatic logic [15:0] f_add(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, em;
    logic [41:0] xa, xb, mag;
    logic s;
    if (f_nan(a) || f_nan(b) || (f_inf(a) && f_inf(b) && (a[15] != b[15]))) return 16'h7E00;
    if (f_inf(a)) return a;
    if (f_inf(b)) return b;
    ea = f_exp(a);
    eb = f_exp(b);
    em = (ea < eb) ? ea : eb;
    xa = {31'd0, |a[14:10], a[9:0]} << (ea - em);
    xb = {31'd0, |b[14:10], b[9:0]} << (eb - em);
    if (a[15] == b[15]) begin
      mag = xa + xb;
      s   = a[15];
    end else if (xa >= xb) begin
      mag = xa - xb;
      s   = a[15];
    end else begin
      mag = xb - xa;
      s   = b[15];
    end
    // Exact cancellation gives +0 unless both operands were negative.
    if (mag == '0) s = a[15] & b[15];
    return f_pack(s, mag, em - 25);
  endfunction

  logic [IW-1:0] r_idx;
  logic          r_run, r_done;
  logic [15:0]   r_acc;
  logic [15:0]   w_prod, w_sum;

  assign w_prod = f_mul(i_vector_a[r_idx], i_vector_b[r_idx]);
  assign w_sum  = (r_idx == '0) ? w_prod : f_add(r_acc, w_prod);
  assign o_done = r_done;
  assign o_c    = r_acc;

  // One product-accumulate per cycle; o_done is a level held until the next start.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_idx  <= '0;
      r_run  <= 1'b0;
      r_done <= 1'b0;
      r_acc  <= '0;
    end else if (i_start) begin
      r_idx  <= '0;
      r_run  <= 1'b1;
      r_done <= 1'b0;
    end else if (r_run) begin
      r_acc <= w_sum;
      if (r_idx == IW'(HEIGHT - 1)) begin
        r_run  <= 1'b0;
        r_done <= 1'b1;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end
endmodule

module half_dot_m_v #(
  parameter int WIDTH  = 10,
  parameter int HEIGHT = 10
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               start,
  input  logic [HEIGHT-1:0][15:0]            vector,
  input  logic [WIDTH-1:0][HEIGHT-1:0][15:0] matrix,
  output logic                               busy,
  output logic                               done,
  output logic [WIDTH-1:0][15:0]             vector_out
);
  localparam int RW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_STORE, S_FINISH} state_t;

  state_t                   r_state, w_next;
  logic [RW-1:0]            r_row;
  logic                     r_done_q;
  logic [WIDTH-1:0][15:0]   r_vout;
  logic                     w_sub_start, w_sub_done, w_sub_edge, w_last;
  logic [15:0]              w_c;

  assign w_sub_edge = w_sub_done & ~r_done_q;
  assign w_last     = (r_row == RW'(WIDTH - 1));
  assign vector_out = r_vout;

  half_dot_v_v #(.HEIGHT(HEIGHT)) u_dot (
    .clk        (clk),
    .rstn       (rstn),
    .i_start    (w_sub_start),
    .i_vector_a (vector),
    .i_vector_b (matrix[r_row]),
    .o_done     (w_sub_done),
    .o_c        (w_c)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_row    <= '0;
      r_done_q <= 1'b0;
      r_vout   <= '0;
    end else begin
      r_state  <= w_next;
      r_done_q <= w_sub_done;
      if (r_state == S_IDLE && start) r_row <= '0;
      if (r_state == S_STORE) begin
        r_vout[r_row] <= w_c;
        if (!w_last) r_row <= r_row + 1'b1;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    busy        = 1'b1;
    done        = 1'b0;
    w_sub_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_LAUNCH;
      end
      S_LAUNCH: begin
        w_sub_start = 1'b1;
        w_next      = S_WAIT;
      end
      S_WAIT:   if (w_sub_edge) w_next = S_STORE;
      S_STORE:  w_next = w_last ? S_FINISH : S_LAUNCH;
      S_FINISH: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end
endmodule
